ram_loader: RTL and testbench

RAM_LOADER -- requirements
Module: ram_loader

---
 rtl/ram_loader.sv | 144 ++++++++++++++
 tb/tb_ram_loader.sv | 325 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ram_loader.sv
// Byte-serial program loader: receives PROG_LEN bytes, writes them to a 16x8 RAM
// through the MAR manual path while holding the CPU. Optional trailing checksum: RAM_LOADER_CHECKSUM_EN.
module ram_loader #(
    parameter int PROG_LEN   = 16,
    parameter int ADDR_WIDTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  abort,
    input  logic                  byte_valid,
    input  logic [7:0]            byte_data,
    output logic                  byte_ready,
    output logic                  cpu_hold,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_wdata,
    output logic                  ram_we,
    output logic                  busy,
    output logic                  done,
    output logic                  error,
    output logic [2:0]            dbg_state
);

    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_RECV  = 3'd1;
    localparam logic [2:0] S_SETUP = 3'd2;
    localparam logic [2:0] S_WRITE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;
`ifdef RAM_LOADER_CHECKSUM_EN
    localparam logic [2:0] S_CHECK = 3'd5;
`endif

    localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(PROG_LEN - 1);

    logic [2:0]            state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic [7:0]            wdata_q, wdata_d;
    logic                  error_q, error_d;
    logic                  xfer;
`ifdef RAM_LOADER_CHECKSUM_EN
    logic [7:0]            csum_q, csum_d;
`endif

    // A byte moves only when byte_valid and byte_ready are both high at the rising edge;
    // abort withdraws ready so an aborted cycle can never look like a transfer.
`ifdef RAM_LOADER_CHECKSUM_EN
    assign byte_ready = ~abort & ((state_q == S_RECV) | (state_q == S_CHECK));
`else
    assign byte_ready = ~abort & (state_q == S_RECV);
`endif
    assign xfer      = byte_valid & byte_ready;
    assign ram_we    = ~abort & (state_q == S_WRITE);
    assign busy      = (state_q != S_IDLE);
    assign cpu_hold  = busy;
    assign done      = (state_q == S_DONE);
    assign error     = error_q;
    assign ram_addr  = addr_q;
    assign ram_wdata = wdata_q;
    assign dbg_state = state_q;

    always_comb begin
        state_d = state_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        error_d = error_q;
`ifdef RAM_LOADER_CHECKSUM_EN
        csum_d  = csum_q;
`endif
        if (abort && (state_q != S_IDLE)) begin
            state_d = S_IDLE;
            error_d = 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_d = S_RECV;
                        addr_d  = '0;
                        error_d = 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
                        csum_d  = '0;
`endif
                    end
                end
                S_RECV: begin
                    if (xfer) begin
                        wdata_d = byte_data;
`ifdef RAM_LOADER_CHECKSUM_EN
                        csum_d  = csum_q + byte_data;
`endif
                        state_d = S_SETUP;
                    end
                end
                S_SETUP: state_d = S_WRITE;
                S_WRITE: begin
                    if (addr_q == LAST_ADDR) begin
`ifdef RAM_LOADER_CHECKSUM_EN
                        state_d = S_CHECK;
`else
                        state_d = S_DONE;
`endif
                    end else begin
                        addr_d  = addr_q + 1'b1;
                        state_d = S_RECV;
                    end
                end
`ifdef RAM_LOADER_CHECKSUM_EN
                S_CHECK: begin
                    if (xfer) begin
                        if (byte_data == csum_q) begin
                            state_d = S_DONE;
                        end else begin
                            error_d = 1'b1;
                            state_d = S_IDLE;
                        end
                    end
                end
`endif
                S_DONE:  state_d = S_IDLE;
                default: state_d = S_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            addr_q  <= '0;
            wdata_q <= '0;
            error_q <= 1'b0;
`ifdef RAM_LOADER_CHECKSUM_EN
            csum_q  <= '0;
`endif
        end else begin
            state_q <= state_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            error_q <= error_d;
`ifdef RAM_LOADER_CHECKSUM_EN
            csum_q  <= csum_d;
`endif
        end
    end

endmodule

// File: tb/tb_ram_loader.sv
// Bench for ram_loader: a PROG_LEN=16 and a PROG_LEN=4 instance share one byte source;
// a write log per instance is compared against expectations built from the payload.
module tb_ram_loader;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0, abort = 1'b0, byte_valid = 1'b0;
    logic [7:0] byte_data = 8'h00;

    logic r16, h16, we16, b16, d16, e16;
    logic [3:0] a16;
    logic [7:0] wd16;
    logic [2:0] st16;
    logic r4, h4, we4, b4, d4, e4;
    logic [3:0] a4;
    logic [7:0] wd4;
    logic [2:0] st4;

    ram_loader #(.PROG_LEN(16), .ADDR_WIDTH(4)) dut16 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(r16),
        .cpu_hold(h16), .ram_addr(a16), .ram_wdata(wd16), .ram_we(we16),
        .busy(b16), .done(d16), .error(e16), .dbg_state(st16));

    ram_loader #(.PROG_LEN(4), .ADDR_WIDTH(4)) dut4 (
        .clk(clk), .rst(rst), .start(start), .abort(abort),
        .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(r4),
        .cpu_hold(h4), .ram_addr(a4), .ram_wdata(wd4), .ram_we(we4),
        .busy(b4), .done(d4), .error(e4), .dbg_state(st4));

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cycle = 0;
    bit sel = 1'b0;

    logic [11:0] act16[$], act4[$];
    int          cyc16[$], cyc4[$];
    int          done_cnt16 = 0, done_cnt4 = 0;
    logic [11:0] exp_q[$];
    logic [7:0]  pay[$];

    typedef struct {
        logic       st;
        logic       ab;
        logic       vl;
        logic [7:0] dt;
        logic [17:0] ex;
    } vec_t;
    vec_t tbl[11];

    always @(posedge clk) cycle <= cycle + 1;

    // Write/done monitor, sampled mid-low-phase when inputs and outputs are settled
    always @(negedge clk) begin
        #2;
        if (we16) begin act16.push_back({a16, wd16}); cyc16.push_back(cycle); end
        if (we4)  begin act4.push_back({a4, wd4});    cyc4.push_back(cycle);  end
        if (d16) done_cnt16++;
        if (d4)  done_cnt4++;
    end

    function automatic logic [17:0] mk(input logic b, r, w, h, d, e,
                                       input logic [3:0] a, input logic [7:0] wd);
        return {b, r, w, h, d, e, a, wd};
    endfunction

    function automatic logic [17:0] obs();
        if (sel) return {b4, r4, we4, h4, d4, e4, a4, wd4};
        return {b16, r16, we16, h16, d16, e16, a16, wd16};
    endfunction

    function automatic logic ready_s();
        return sel ? r4 : r16;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
        end
    endtask

    task automatic clear_logs();
        act16.delete(); act4.delete(); cyc16.delete(); cyc4.delete();
        done_cnt16 = 0; done_cnt4 = 0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1; start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        clear_logs();
    endtask

    task automatic start_session();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap);
        int n = 0;
        repeat (gap) begin @(negedge clk); byte_valid = 1'b0; end
        @(negedge clk);
        byte_valid = 1'b1;
        byte_data  = b;
        while (!ready_s() && n < 100) begin @(negedge clk); n++; end
        if (n >= 100) begin
            check("send_byte_timeout", 32'(n), 32'd0);
            byte_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1 byte_valid = 1'b0;
        end
    endtask

    // Waits for the done pulse, then checks hold during done and release right after
    task automatic wait_done(input string tag);
        int n = 0;
        @(negedge clk);
        while (!(sel ? d4 : d16) && n < 200) begin @(negedge clk); n++; end
        check({tag, " done_seen"}, 32'(n < 200), 32'd1);
        check({tag, " hold_at_done"}, 32'(sel ? h4 : h16), 32'd1);
        @(negedge clk);
        check({tag, " hold_after_done"}, 32'({sel ? h4 : h16, sel ? b4 : b16}), 32'd0);
    endtask

    // Reference: accepted byte i lands at address i, never beyond PROG_LEN-1
    task automatic build_exp(input int plen, input int n);
        exp_q.delete();
        for (int i = 0; i < n && i < plen; i++) exp_q.push_back({4'(i), pay[i]});
    endtask

    task automatic check_session(input int exp_done, input string tag);
        logic [11:0] got[$];
        int dc;
        @(negedge clk);
        #3;
        got = sel ? act4 : act16;
        dc  = sel ? done_cnt4 : done_cnt16;
        check({tag, " wr_count"}, 32'(got.size()), 32'(exp_q.size()));
        for (int i = 0; i < got.size() && i < exp_q.size(); i++)
            check($sformatf("%s wr[%0d]", tag, i), 32'(got[i]), 32'(exp_q[i]));
        check({tag, " done_count"}, 32'(dc), 32'(exp_done));
    endtask

    function automatic logic [7:0] sum_pay(input int n);
        logic [7:0] s = 8'h00;
        for (int i = 0; i < n; i++) s = s + pay[i];
        return s;
    endfunction

    task automatic full_session(input int plen, input int gapmax, input string tag);
        start_session();
        for (int i = 0; i < plen; i++) send_byte(pay[i], $urandom_range(gapmax, 0));
`ifdef RAM_LOADER_CHECKSUM_EN
        send_byte(sum_pay(plen), $urandom_range(gapmax, 0));
`endif
        wait_done(tag);
        build_exp(plen, plen);
        check_session(1, tag);
    endtask

    initial begin
        int plen;
        int k;
        // reset state
        #12;
        check("reset_outputs", 32'({obs(), st16 == 3'd0}), 32'({18'd0, 1'b1}));
        @(negedge clk);
        rst = 1'b0;

        tbl[0]  = '{1'b0, 1'b1, 1'b0, 8'h00, mk(0, 0, 0, 0, 0, 0, 4'd0, 8'h00)};
        tbl[1]  = '{1'b1, 1'b0, 1'b0, 8'h00, mk(1, 1, 0, 1, 0, 0, 4'd0, 8'h00)};
        tbl[2]  = '{1'b1, 1'b0, 1'b0, 8'h00, mk(1, 1, 0, 1, 0, 0, 4'd0, 8'h00)};
        tbl[3]  = '{1'b0, 1'b0, 1'b1, 8'hA5, mk(1, 0, 0, 1, 0, 0, 4'd0, 8'hA5)};
        tbl[4]  = '{1'b0, 1'b0, 1'b0, 8'h00, mk(1, 0, 1, 1, 0, 0, 4'd0, 8'hA5)};
        tbl[5]  = '{1'b0, 1'b0, 1'b0, 8'h00, mk(1, 1, 0, 1, 0, 0, 4'd1, 8'hA5)};
        tbl[6]  = '{1'b0, 1'b1, 1'b1, 8'h3C, mk(0, 0, 0, 0, 0, 1, 4'd1, 8'hA5)};
        tbl[7]  = '{1'b0, 1'b0, 1'b0, 8'h00, mk(0, 0, 0, 0, 0, 1, 4'd1, 8'hA5)};
        tbl[8]  = '{1'b1, 1'b0, 1'b0, 8'h00, mk(1, 1, 0, 1, 0, 0, 4'd0, 8'hA5)};
        tbl[9]  = '{1'b1, 1'b0, 1'b1, 8'h3C, mk(1, 0, 0, 1, 0, 0, 4'd0, 8'h3C)};
        tbl[10] = '{1'b0, 1'b1, 1'b0, 8'h00, mk(0, 0, 0, 0, 0, 1, 4'd0, 8'h3C)};

        sel = 1'b0;
        for (int i = 0; i < 11; i++) begin
            @(negedge clk);
            start = tbl[i].st; abort = tbl[i].ab;
            byte_valid = tbl[i].vl; byte_data = tbl[i].dt;
            @(posedge clk);
            #1;
            start = 1'b0; abort = 1'b0; byte_valid = 1'b0;
            #1 check($sformatf("vec[%0d]", i), 32'(obs()), 32'(tbl[i].ex));
        end

        // full load 0x00..0x0F, valid held, 3-cycle cadence
        do_reset();
        pay.delete();
        for (int i = 0; i < 16; i++) pay.push_back(8'(i));
        full_session(16, 0, "full_load");
        for (int i = 1; i < cyc16.size(); i++)
            check($sformatf("cadence[%0d]", i), 32'(cyc16[i] - cyc16[i-1]), 32'd3);

        // back-pressure: valid drops for one cycle before each byte
        do_reset();
        pay.delete();
        for (int i = 0; i < 16; i++) pay.push_back(8'($urandom_range(255, 0)));
        start_session();
        for (int i = 0; i < 16; i++) send_byte(pay[i], 1);
`ifdef RAM_LOADER_CHECKSUM_EN
        send_byte(sum_pay(16), 1);
`endif
        wait_done("backpressure");
        build_exp(16, 16);
        check_session(1, "backpressure");

        // abort in WRITE of byte 6: five writes survive, error set, then cleared by start
        do_reset();
        start_session();
        for (int i = 0; i < 6; i++) send_byte(pay[i], 0);
        k = 0;
        @(negedge clk);
        while (!we16 && k < 10) begin @(negedge clk); k++; end
        abort = 1'b1;
        #1 check("abort_we_forced_low", 32'(we16), 32'd0);
        @(posedge clk);
        #1 abort = 1'b0;
        #1 check("abort_idle_error", 32'({b16, e16, h16}), 32'b010);
        repeat (3) @(negedge clk);
        build_exp(16, 5);
        check_session(0, "abort");
        start_session();
        #1 check("restart_clears_error", 32'({b16, e16}), 32'b10);

        // asynchronous reset between edges while in WRITE
        do_reset();
        start_session();
        for (int i = 0; i < 3; i++) send_byte(pay[i], 0);
        k = 0;
        @(negedge clk);
        while (!we16 && k < 10) begin @(negedge clk); k++; end
        check("pre_rst_in_write", 32'(we16), 32'd1);
        #1 rst = 1'b1;
        #1 check("async_rst_outputs", 32'(obs()), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        build_exp(16, 2);
        check_session(0, "rst_in_write");

`ifdef RAM_LOADER_CHECKSUM_EN
        // checksum of sixteen 0x11 bytes is 0x10
        for (int t = 0; t < 2; t++) begin
            do_reset();
            pay.delete();
            for (int i = 0; i < 16; i++) pay.push_back(8'h11);
            start_session();
            for (int i = 0; i < 16; i++) send_byte(pay[i], 0);
            send_byte((t == 0) ? 8'h10 : 8'h11, 0);
            repeat (3) @(negedge clk);
            build_exp(16, 16);
            check_session((t == 0) ? 1 : 0, (t == 0) ? "csum_good" : "csum_bad");
            check((t == 0) ? "csum_good_err" : "csum_bad_err", 32'({e16, b16}),
                  (t == 0) ? 32'b00 : 32'b10);
        end
`endif

        // PROG_LEN=4 instance, start pulsed mid-session
        sel = 1'b1;
        do_reset();
        pay.delete();
        for (int i = 0; i < 8; i++) pay.push_back(8'($urandom_range(255, 0)));
        start_session();
        send_byte(pay[0], 0);
        send_byte(pay[1], 0);
        start_session();
        send_byte(pay[2], 0);
        send_byte(pay[3], 0);
`ifdef RAM_LOADER_CHECKSUM_EN
        send_byte(sum_pay(4), 0);
`endif
        wait_done("len4");
        repeat (4) @(negedge clk);
        check("len4_stays_idle", 32'(b4), 32'd0);
        build_exp(4, 4);
        check_session(1, "len4");

        // randomized sessions on both instances, some aborted
        for (int s = 0; s < 8; s++) begin
            sel  = s[0];
            plen = sel ? 4 : 16;
            do_reset();
            pay.delete();
            for (int i = 0; i < plen; i++) pay.push_back(8'($urandom()));
            if (s % 4 == 3) begin
                k = $urandom_range(plen - 1, 0);
                start_session();
                for (int i = 0; i <= k; i++) send_byte(pay[i], $urandom_range(3, 0));
                abort = 1'b1;
                @(posedge clk);
                #1 abort = 1'b0;
                repeat (3) @(negedge clk);
                check($sformatf("rnd%0d abort_err", s), 32'(sel ? e4 : e16), 32'd1);
                build_exp(plen, k);
                check_session(0, $sformatf("rnd%0d", s));
            end else begin
                full_session(plen, 3, $sformatf("rnd%0d", s));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1);
    end

endmodule
